// File: rtl/qoi_types.sv
// Shared QOI types, opcodes and the colour-index hash used by both the
// encoder and decoder accelerators.
package qoi_types;

    // Byte order on the bus: [7:0]=r, [15:8]=g, [23:16]=b, [31:24]=a.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef logic [29:0] size_t;

    localparam logic [7:0] QOI_OP_RGB  = 8'hFE;
    localparam logic [7:0] QOI_OP_RGBA = 8'hFF;

    localparam logic [1:0] QOI_TAG_INDEX = 2'b00;
    localparam logic [1:0] QOI_TAG_DIFF  = 2'b01;
    localparam logic [1:0] QOI_TAG_LUMA  = 2'b10;
    localparam logic [1:0] QOI_TAG_RUN   = 2'b11;

    // Multi-byte ops waiting for their argument bytes.
    typedef enum logic [1:0] {
        K_RGB,
        K_RGBA,
        K_LUMA
    } op_kind_t;

    // (r*3 + g*5 + b*7 + a*11) mod 64.
    function automatic logic [5:0] qoi_hash(input pixel_t p);
        return 6'({4'b0, p.r} * 12'd3 + {4'b0, p.g} * 12'd5 +
                  {4'b0, p.b} * 12'd7 + {4'b0, p.a} * 12'd11);
    endfunction

endpackage

// File: rtl/qoi_index_table.sv
// 64-entry table of previously seen pixels: asynchronous read, one
// synchronous write port, cleared by reset or by a synchronous clear.
module qoi_index_table
    import qoi_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       we,
    input  logic [5:0] waddr,
    input  pixel_t     wdata,
    input  logic [5:0] raddr,
    output pixel_t     rdata
);

    pixel_t mem [64];

    // Table storage: every entry must read as zero at frame start.
    // NOTE: this memory is built from resettable flops on purpose; the decoder
    // relies on a known-zero table, so it cannot be a plain RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: one byte per handshake in, one RGBA pixel per
// handshake out. The header is stripped by software and the end marker is
// never consumed because the frame ends on the pixel count.
module qoi_decoder
    import qoi_types::*;
#(
    parameter logic [31:0] PREV_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] size,
    output logic        busy,
    output logic        done,
    output logic [29:0] count_o,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] px_o,
    output logic        px_valid,
    input  logic        px_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ARGS,
        S_EMIT,
        S_RUN
    } state_t;

    state_t    state;
    size_t     size_r;
    size_t     count;
    pixel_t    prev;
    pixel_t    px_r;
    op_kind_t  kind;
    logic [2:0]  args_left;
    logic [23:0] args;      // op byte and arguments received so far
    logic [6:0]  run_left;

    pixel_t      index_rdata;
    pixel_t      op_px;
    pixel_t      args_px;
    logic [31:0] window;
    logic [7:0]  dg;
    size_t       count_inc;
    logic        px_fire;
    logic        clr_index;

    assign count_inc = count + 30'd1;
    assign px_fire   = px_valid && px_ready;
    assign clr_index = (state == S_IDLE) && start;
    assign window    = {args, in_data};
    assign dg        = {2'b00, window[13:8]} - 8'd32;

    assign count_o = count;
    assign px_o    = px_r;

    qoi_index_table u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_index),
        .we    (px_fire),
        .waddr (qoi_hash(px_r)),
        .wdata (px_r),
        .raddr (in_data[5:0]),
        .rdata (index_rdata)
    );

    // Single-byte ops: INDEX lookup or DIFF from the previous pixel.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        op_px = prev;
        if (in_data[7:6] == QOI_TAG_INDEX) begin
            op_px = index_rdata;
        end else begin
            op_px.r = prev.r + {6'b0, in_data[5:4]} - 8'd2;
            op_px.g = prev.g + {6'b0, in_data[3:2]} - 8'd2;
            op_px.b = prev.b + {6'b0, in_data[1:0]} - 8'd2;
        end
    end

    // Multi-byte ops, formed as the final argument byte arrives.
    always_comb begin
        args_px = prev;
        unique case (kind)
            K_RGB: begin
                args_px.r = window[23:16];
                args_px.g = window[15:8];
                args_px.b = window[7:0];
            end
            K_RGBA: begin
                args_px.r = window[31:24];
                args_px.g = window[23:16];
                args_px.b = window[15:8];
                args_px.a = window[7:0];
            end
            default: begin
                args_px.r = prev.r + dg + {4'b0, window[7:4]} - 8'd8;
                args_px.g = prev.g + dg;
                args_px.b = prev.b + dg + {4'b0, window[3:0]} - 8'd8;
            end
        endcase
    end

    // Frame control, byte decode and pixel handshake with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            size_r    <= '0;
            in_ready  <= 1'b0;
            px_valid  <= 1'b0;
            px_r      <= '0;
            prev      <= pixel_t'(PREV_INIT);
            kind      <= K_RGB;
            args_left <= '0;
            args      <= '0;
            run_left  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        size_r <= size;
                        count  <= '0;
                        prev   <= pixel_t'(PREV_INIT);
                        if (size == '0) begin
                            done <= 1'b1;
                        end else begin
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (in_valid) begin
                        args <= {args[15:0], in_data};
                        if (in_data == QOI_OP_RGB) begin
                            kind      <= K_RGB;
                            args_left <= 3'd3;
                            state     <= S_ARGS;
                        end else if (in_data == QOI_OP_RGBA) begin
                            kind      <= K_RGBA;
                            args_left <= 3'd4;
                            state     <= S_ARGS;
                        end else if (in_data[7:6] == QOI_TAG_LUMA) begin
                            kind      <= K_LUMA;
                            args_left <= 3'd1;
                            state     <= S_ARGS;
                        end else if (in_data[7:6] == QOI_TAG_RUN) begin
                            run_left <= {1'b0, in_data[5:0]} + 7'd1;
                            px_r     <= prev;
                            in_ready <= 1'b0;
                            px_valid <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            px_r     <= op_px;
                            in_ready <= 1'b0;
                            px_valid <= 1'b1;
                            state    <= S_EMIT;
                        end
                    end
                end
                S_ARGS: begin
                    if (in_valid) begin
                        args      <= {args[15:0], in_data};
                        args_left <= args_left - 3'd1;
                        if (args_left == 3'd1) begin
                            px_r     <= args_px;
                            in_ready <= 1'b0;
                            px_valid <= 1'b1;
                            state    <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (px_ready) begin
                        prev     <= px_r;
                        count    <= count_inc;
                        px_valid <= 1'b0;
                        if (count_inc == size_r) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_OP;
                        end
                    end
                end
                S_RUN: begin
                    if (px_ready) begin
                        count <= count_inc;
                        if (count_inc == size_r) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            px_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else if (run_left == 7'd1) begin
                            px_valid <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= S_OP;
                        end else begin
                            run_left <= run_left - 7'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: hand-computed byte streams and pixels.
module tb_qoi_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [29:0] size = '0;
    logic        busy;
    logic        done;
    logic [29:0] count_o;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] px_o;
    logic        px_valid;
    logic        px_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qoi_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .size     (size),
        .busy     (busy),
        .done     (done),
        .count_o  (count_o),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .px_o     (px_o),
        .px_valid (px_valid),
        .px_ready (px_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [29:0] n);
        start = 1'b1;
        size  = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic expect_px(input string tag, input logic [31:0] exp);
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (px_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check(tag, px_o, exp);
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {2'b0, count_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_px_valid", {31'd0, px_valid}, 32'd0);
        check("rst_px_o", px_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // RGBA, one pixel, latency of one cycle after the last byte.
        start_frame(30'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send_bytes('{8'hFF, 8'h10, 8'h20, 8'h30, 8'h40});
        check("t1_latency", {31'd0, px_valid}, 32'd1);
        expect_px("t1_px", 32'h4030_2010);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_count", {2'b0, count_o}, 32'd1);
        check("t1_idle_ready", {31'd0, in_ready}, 32'd0);

        // RGB then DIFF; a start pulse mid-frame must be ignored.
        start_frame(30'd2);
        check("t2_done_clr", {31'd0, done}, 32'd0);
        send_bytes('{8'hFE, 8'h0A, 8'h0B, 8'h0C});
        expect_px("t2_rgb", 32'h000C_0B0A);
        start_frame(30'd7);
        send_byte(8'h79);
        expect_px("t2_diff", 32'h000B_0B0B);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_count", {2'b0, count_o}, 32'd2);

        // LUMA.
        start_frame(30'd2);
        send_bytes('{8'hFE, 8'h64, 8'h64, 8'h64});
        expect_px("t3_rgb", 32'h0064_6464);
        send_bytes('{8'hA5, 8'h6B});
        expect_px("t3_luma", 32'h006C_6967);

        // INDEX lookup of the first pixel (hash 14).
        start_frame(30'd3);
        send_bytes('{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04});
        expect_px("t4_rgba", 32'h0403_0201);
        send_bytes('{8'hFE, 8'h00, 8'h00, 8'h00});
        expect_px("t4_rgb", 32'h0400_0000);
        send_byte(8'h0E);
        expect_px("t4_index", 32'h0403_0201);
        check("t4_count", {2'b0, count_o}, 32'd3);

        // RUN of 4 with a 3-cycle stall in the middle.
        start_frame(30'd5);
        send_bytes('{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04});
        expect_px("t5_first", 32'h0403_0201);
        send_byte(8'hC3);
        expect_px("t5_run0", 32'h0403_0201);
        expect_px("t5_run1", 32'h0403_0201);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_px", px_o, 32'h0403_0201);
            check("t5_stall_valid", {31'd0, px_valid}, 32'd1);
            check("t5_stall_count", {2'b0, count_o}, 32'd3);
        end
        expect_px("t5_run2", 32'h0403_0201);
        expect_px("t5_run3", 32'h0403_0201);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_count", {2'b0, count_o}, 32'd5);
        check("t5_no_extra", {31'd0, px_valid}, 32'd0);

        // Run truncated by the frame size; trailing byte is not consumed.
        start_frame(30'd2);
        send_bytes('{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04});
        expect_px("t6_first", 32'h0403_0201);
        send_byte(8'hC9);
        expect_px("t6_run", 32'h0403_0201);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_no_extra", {31'd0, px_valid}, 32'd0);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_not_consumed", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;

        // size=0 finishes immediately without touching the byte stream.
        start_frame(30'd0);
        check("t7_done", {31'd0, done}, 32'd1);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_in_ready", {31'd0, in_ready}, 32'd0);

        // Asynchronous reset mid-frame, then the index must read back zero.
        start_frame(30'd3);
        send_bytes('{8'hFF, 8'h01});
        #2 rst_n = 1'b0;
        #1;
        check("t8_busy", {31'd0, busy}, 32'd0);
        check("t8_px_valid", {31'd0, px_valid}, 32'd0);
        check("t8_in_ready", {31'd0, in_ready}, 32'd0);
        #4 rst_n = 1'b1;
        tick();
        start_frame(30'd1);
        send_byte(8'h0E);
        expect_px("t8_index_clr", 32'h0000_0000);
        check("t8_done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
